// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures load data or the ALU result with its
// destination and control, and feeds the register-file write port and forwarding.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  load_cnt
);

    logic              valid_reg;
    logic              regwrite_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CNT_W-1:0]  retire_reg;
    logic [CNT_W-1:0]  load_reg;

    // Memory read data is only valid in the cycle its address is presented,
    // so the write-back select is resolved here rather than downstream.
    logic [DATA_W-1:0] data_next;
    assign data_next = in_memtoreg ? mem_dataout : in_alu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            rd_reg       <= '0;
            data_reg     <= '0;
            retire_reg   <= '0;
            load_reg     <= '0;
        end else if (flush) begin
            // Bubble: counters are left untouched.
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            rd_reg       <= '0;
            data_reg     <= '0;
        end else if (!stall) begin
            valid_reg    <= in_valid;
            regwrite_reg <= in_valid & in_regwrite;
            rd_reg       <= in_rd;
            data_reg     <= data_next;
            if (in_valid) begin
                retire_reg <= retire_reg + 1'b1;
            end
            if (in_valid & in_memtoreg) begin
                load_reg <= load_reg + 1'b1;
            end
        end
    end

    // Register 0 is hard-wired zero, so it is never written.
    assign wb_we      = valid_reg & regwrite_reg & (rd_reg != '0);
    assign wb_valid   = valid_reg;
    assign wb_rd      = rd_reg;
    assign wb_data    = data_reg;
    assign retire_cnt = retire_reg;
    assign load_cnt   = load_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_mem_wb_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, stall, flush;
    logic              in_valid, in_regwrite, in_memtoreg;
    logic [REG_AW-1:0] in_rd;
    logic [DATA_W-1:0] in_alu_result, mem_dataout;
    logic              wb_valid, wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  retire_cnt, load_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: what the WB slot architecturally holds.
    bit      m_valid, m_we;
    int      m_rd;
    longint  m_data;
    int      m_retired, m_loads;   // unbounded counts, reduced modulo 2^CNT_W on compare

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .mem_dataout(mem_dataout),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_cnt(retire_cnt), .load_cnt(load_cnt)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input bit rw, input bit m2r, input int rd,
                          input logic [31:0] alu, input logic [31:0] mem);
        in_valid = v; in_regwrite = rw; in_memtoreg = m2r;
        in_rd = rd[REG_AW-1:0]; in_alu_result = alu; mem_dataout = mem;
    endtask

    // One clock: the model consumes the inputs seen at the edge, then every output is checked.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_data = 0; m_retired = 0; m_loads = 0;
        end else if (flush) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_data = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_rd    = int'(in_rd);
            m_we    = in_valid && in_regwrite && (m_rd != 0);
            m_data  = in_memtoreg ? longint'(mem_dataout) : longint'(in_alu_result);
            if (in_valid) m_retired++;
            if (in_valid && in_memtoreg) m_loads++;
        end
        #1;
        chk({tag, ".valid"},  longint'(wb_valid),   longint'(m_valid));
        chk({tag, ".we"},     longint'(wb_we),      longint'(m_we));
        chk({tag, ".rd"},     longint'(wb_rd),      longint'(m_rd));
        chk({tag, ".data"},   longint'(wb_data),    m_data);
        chk({tag, ".retire"}, longint'(retire_cnt), longint'(m_retired % (1 << CNT_W)));
        chk({tag, ".load"},   longint'(load_cnt),   longint'(m_loads % (1 << CNT_W)));
        $display("[TB] %-10s v=%0d we=%0d rd=%0d data=0x%08h ret=%0d ld=%0d", tag,
                 wb_valid, wb_we, wb_rd, wb_data, retire_cnt, load_cnt);
    endtask

    initial begin
        m_valid = 0; m_we = 0; m_rd = 0; m_data = 0; m_retired = 0; m_loads = 0;
        rst = 1; stall = 0; flush = 0;
        set_in(1, 1, 0, 7, 32'hdead_beef, 32'h1111_2222);
        #1;

        // Reset held for two cycles
        step("reset0");
        step("reset1");
        chk("reset.data_zero", longint'(wb_data), 0);

        // ALU write-back
        rst = 0;
        set_in(1, 1, 0, 3, 32'h0000_1234, 32'hffff_0000);
        step("alu");
        chk("alu.data_lit", longint'(wb_data), 64'h1234);
        chk("alu.we_lit", longint'(wb_we), 1);

        // Load, then the address/data moves on the next cycle
        set_in(1, 1, 1, 5, 32'h0000_0100, 32'h0000_000a);
        step("load");
        chk("load.cnt_lit", longint'(load_cnt), 1);
        stall = 1;
        set_in(1, 1, 1, 9, 32'h0000_0104, 32'h0000_00bb);
        step("load_hold");
        chk("load.data_kept", longint'(wb_data), 64'h0a);

        // Stall with changing inputs, then flush+stall
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, i[0], 10 + i, $urandom, $urandom);
            step("stall");
        end
        flush = 1;
        step("flush_stl");
        chk("flush.we_lit", longint'(wb_we), 0);
        flush = 0; stall = 0;

        // Register 0 and invalid instructions
        set_in(1, 1, 0, 0, 32'h55, 32'h66);
        step("rd0");
        set_in(0, 1, 1, 4, 32'h77, 32'h88);
        step("invalid");

        // Enough valid captures to wrap the narrow counters
        for (int i = 0; i < 18; i++) begin
            set_in(1, $urandom_range(0, 1), 1, $urandom_range(0, 31), $urandom, $urandom);
            step("wrap");
        end

        // Reset asserted during stall and flush
        stall = 1; rst = 1;
        step("rst_stall");
        rst = 0;
        set_in(1, 1, 0, 2, 32'hcafe, 32'h0);
        step("stall_post");
        stall = 0;
        step("resume");
        flush = 1; rst = 1;
        step("rst_flush");
        flush = 0; rst = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) < 2);
            flush = ($urandom_range(0, 99) < 10);
            stall = ($urandom_range(0, 99) < 25);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 31), $urandom, $urandom);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
